serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder that wraps the existing single-bit full_adder with operand shift registers, a carry flip-flop and a bit counter.
- Consumes the full_adder's sum and carry outputs each cycle, LSB first.
- Serves as the area-cheap sequential datapath stage built on the full_adder.
- Uses a start/busy/done handshake toward the controlling logic.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  result register; held between operations.
- cout  output  1  final carry register; held between operations.

Interface decision: one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; operand shift regs, carry FF and counter cleared.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on start=1 at edge E0:
  - Load a_sr=a, b_sr=b, carry=cin, cnt=0.
- SHIFT, each edge:
  - full_adder inputs are a_sr[0], b_sr[0], carry.
  - carry <= fa carry-out.
  - a_sr and b_sr shift right.
  - Result shift reg shifts right with the fa sum bit entering the MSB.
  - cnt increments.
- SHIFT -> DONE at edge E0+WIDTH (the edge where cnt==WIDTH-1). At that same edge:
  - sum <= completed shift value (including the final fa sum bit).
  - cout <= fa carry-out.
- DONE -> IDLE unconditionally on the next edge.
- Output timing:
  - done=1 only during DONE, so it is exactly one cycle, starting WIDTH cycles after the start edge.
  - busy=1 exactly WIDTH cycles.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); no truncation beyond that.
- cnt width is $clog2(WIDTH).
- start while busy or in DONE: ignored, no queuing; the operand inputs are don't-care.
- start held high continuously: a new operation is accepted at the first IDLE edge, i.e. back-to-back throughput is one result per WIDTH+2 cycles.
- sum/cout change only at completion edges or reset, never mid-operation.
- Reset mid-SHIFT: immediate abort to IDLE with all outputs zero; no done pulse for the aborted operation.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined:
  - Extra output port ovf (1 bit, reset 0).
  - ovf is registered at the completion edge as (carry into MSB) XOR (carry out of MSB), i.e. two's-complement signed overflow.
  - ovf is held alongside sum.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg: state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
- The existing full_adder is instantiated once as the bit-slice sub-module; no new sub-module.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, 1-cycle start -> busy high 8 cycles; done pulses in cycle 8; sum=0x7F, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- Start with a=0x10, b=0x20; pulse start again at cycle 3 with a=0x01, b=0x01 -> second request ignored; result sum=0x30; exactly one done pulse.
- Start a=0xAA, b=0x55; assert rst_n low at cycle 4 -> busy/done/sum/cout zero immediately; no done pulse; a fresh start then completes normally.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1. Then a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1. Then a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder: the bit slice reused by the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder around one full_adder, LSB first, start/busy/done handshake.
// Optional signed-overflow flag output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] res_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             fa_sum_s;
    logic             fa_cout_s;
    logic             last_bit_s;

    full_adder u_fa (
        .a    (a_sr_r[0]),
        .b    (b_sr_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    assign last_bit_s = (cnt_r == CNT_LAST);

    // Next-state decode: start is only honoured in IDLE, DONE always returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with handshake flags registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == SHIFT);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Datapath: load on accepted start, shift one bit per SHIFT cycle, publish at the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            res_sr_r <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                    res_sr_r <= {fa_sum_s, res_sr_r[WIDTH-1:1]};
                    carry_r  <= fa_cout_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_bit_s) begin
                        sum_r  <= {fa_sum_s, res_sr_r[WIDTH-1:1]};
                        cout_r <= fa_cout_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // At the last bit carry_r is the carry into the MSB, fa_cout_s the carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if ((state_r == SHIFT) && last_bit_s) begin
            ovf_r <= carry_r ^ fa_cout_s;
        end
    end

    assign ovf = ovf_r;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: stimulus pushes expected results, a monitor checks on done.
// Checks the ovf flag too when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    exp_t         exp_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] prev_sum;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e.s));
                check("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", 32'(ovf), 32'(e.o));
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input int pulse_at);
        int t;
        int bc;
        @(negedge clk);
        a = av; b = bv; cin = ci; start = 1'b1;
        exp_q.push_back('{s: es, c: ec, o: eo});
        @(negedge clk);
        start = 1'b0;
        t  = 0;
        bc = 0;
        while (done !== 1'b1 && t < 40) begin
            if (busy === 1'b1) bc++;
            if (t == 0) check("sum_held", 32'(sum), 32'(prev_sum));
            if (pulse_at != 0 && t == pulse_at) begin
                start = 1'b1; a = 8'h01; b = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check("done_latency", 32'(t), 32'(W));
        check("busy_cycles", 32'(bc), 32'(W));
        check("busy_at_done", 32'(busy), 32'd0);
        prev_sum = es;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int t;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        rst_n = 1'b1;

        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 3);

        // Reset mid-operation: abort, no done, outputs cleared immediately.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        prev_sum = '0;
        repeat (12) @(negedge clk);
        run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 0);

        // Start held high: back-to-back results every W+2 cycles.
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        exp_q.push_back('{s: 8'h10, c: 1'b0, o: 1'b0});
        exp_q.push_back('{s: 8'h10, c: 1'b0, o: 1'b0});
        t = 0;
        while (done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("held_first_latency", 32'(t), 32'(W + 1));
        t = 0;
        @(negedge clk);
        t++;
        while (done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        check("held_gap", 32'(t), 32'(W + 2));
        prev_sum = 8'h10;
        repeat (2) @(negedge clk);

`ifdef SERIAL_ADDER_OVF_EN
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
        run_op(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 0);
`endif

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
